// File: rtl/pll_lock_sequencer.sv
// PLL reset/lock sequencer on refclk: pulses PLL reset, waits for and qualifies lock, then releases sys_reset.
// Define PLL_RETRY_LIMIT_EN to bound lock timeouts with a sticky FAIL state (fail_o tied 0 otherwise).
module pll_lock_sequencer #(
    parameter int RST_CYCLES    = 16,
    parameter int LOCK_TIMEOUT  = 65536,
    parameter int STABLE_CYCLES = 1024,
    parameter int SYNC_STAGES   = 2,
    parameter int MAX_RETRIES   = 4
) (
    input  logic       refclk_i,
    input  logic       rst_i,
    input  logic       pll_locked_i,
    output logic       pll_rst_o,
    output logic       sys_reset_o,
    output logic       ready_o,
    output logic       fail_o,
    output logic [7:0] lock_loss_cnt_o
);
    localparam int MAX_AB  = (RST_CYCLES > LOCK_TIMEOUT) ? RST_CYCLES : LOCK_TIMEOUT;
    localparam int MAX_CYC = (MAX_AB > STABLE_CYCLES) ? MAX_AB : STABLE_CYCLES;
    localparam int CW      = $clog2(MAX_CYC) + 1;

    localparam logic [CW-1:0] RST_LAST     = CW'(RST_CYCLES - 1);
    localparam logic [CW-1:0] TIMEOUT_LAST = CW'(LOCK_TIMEOUT - 1);
    // The locked sample that moved us out of WAIT_LOCK is the first of the stable window.
    localparam logic [CW-1:0] STABLE_LAST  = CW'((STABLE_CYCLES >= 2) ? STABLE_CYCLES - 2 : 0);

    if (RST_CYCLES < 1 || LOCK_TIMEOUT < 2 || STABLE_CYCLES < 1 || SYNC_STAGES < 2 || MAX_RETRIES < 1) begin : g_bad_params
        $error("pll_lock_sequencer: illegal parameter value");
    end

    typedef enum logic [2:0] {
        S_PLL_RST   = 3'd0,
        S_WAIT_LOCK = 3'd1,
        S_STABLE    = 3'd2,
        S_RUN       = 3'd3,
        S_FAIL      = 3'd4
    } state_t;

    state_t          state_q, state_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic [7:0]      lock_loss_q, lock_loss_d;
    logic            pll_rst_q, pll_rst_d;
    logic            sys_reset_q, sys_reset_d;
    logic            ready_q, ready_d;
    logic            fail_q, fail_d;
    logic [SYNC_STAGES-1:0] sync_q;
    logic            locked_s;

`ifdef PLL_RETRY_LIMIT_EN
    localparam int RW = $clog2(MAX_RETRIES + 1);
    localparam logic [RW-1:0] RETRY_LAST = RW'(MAX_RETRIES - 1);
    logic [RW-1:0]   retry_q, retry_d;
`endif

    always_ff @(posedge refclk_i or posedge rst_i) begin
        if (rst_i) begin
            sync_q <= '0;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], pll_locked_i};
        end
    end

    assign locked_s = sync_q[SYNC_STAGES-1];

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        lock_loss_d = lock_loss_q;
`ifdef PLL_RETRY_LIMIT_EN
        retry_d     = retry_q;
`endif
        case (state_q)
            S_PLL_RST: begin
                cnt_d = cnt_q + 1'b1;
                if (cnt_q == RST_LAST) begin
                    state_d = S_WAIT_LOCK;
                end
            end
            S_WAIT_LOCK: begin
                cnt_d = cnt_q + 1'b1;
                if (locked_s) begin
                    state_d = (STABLE_CYCLES == 1) ? S_RUN : S_STABLE;
                end else if (cnt_q == TIMEOUT_LAST) begin
`ifdef PLL_RETRY_LIMIT_EN
                    if (retry_q == RETRY_LAST) begin
                        state_d = S_FAIL;
                    end else begin
                        retry_d = retry_q + 1'b1;
                        state_d = S_PLL_RST;
                    end
`else
                    state_d = S_PLL_RST;
`endif
                end
            end
            S_STABLE: begin
                cnt_d = cnt_q + 1'b1;
                if (!locked_s) begin
                    state_d = S_PLL_RST;
                end else if (cnt_q == STABLE_LAST) begin
                    state_d = S_RUN;
                end
            end
            S_RUN: begin
                if (!locked_s) begin
                    state_d = S_PLL_RST;
                    if (lock_loss_q != 8'hFF) begin
                        lock_loss_d = lock_loss_q + 8'd1;
                    end
                end
            end
`ifdef PLL_RETRY_LIMIT_EN
            S_FAIL: begin
                state_d = S_FAIL;
            end
`endif
            default: begin
                state_d = S_PLL_RST;
            end
        endcase

        if (state_d != state_q) begin
            cnt_d = '0;
        end
`ifdef PLL_RETRY_LIMIT_EN
        if (state_d == S_RUN) begin
            retry_d = '0;
        end
        fail_d      = (state_d == S_FAIL);
`else
        fail_d      = 1'b0;
`endif
        // Outputs are decoded from the next state so they change on the transition edge itself.
        pll_rst_d   = (state_d == S_PLL_RST) || (state_d == S_FAIL);
        sys_reset_d = (state_d != S_RUN);
        ready_d     = (state_d == S_RUN);
    end

    always_ff @(posedge refclk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q     <= S_PLL_RST;
            cnt_q       <= '0;
            lock_loss_q <= 8'd0;
            pll_rst_q   <= 1'b1;
            sys_reset_q <= 1'b1;
            ready_q     <= 1'b0;
            fail_q      <= 1'b0;
`ifdef PLL_RETRY_LIMIT_EN
            retry_q     <= '0;
`endif
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            lock_loss_q <= lock_loss_d;
            pll_rst_q   <= pll_rst_d;
            sys_reset_q <= sys_reset_d;
            ready_q     <= ready_d;
            fail_q      <= fail_d;
`ifdef PLL_RETRY_LIMIT_EN
            retry_q     <= retry_d;
`endif
        end
    end

    assign pll_rst_o       = pll_rst_q;
    assign sys_reset_o     = sys_reset_q;
    assign ready_o         = ready_q;
    assign fail_o          = fail_q;
    assign lock_loss_cnt_o = lock_loss_q;
endmodule

// File: tb/tb_pll_lock_sequencer.sv
// Self-checking bench for pll_lock_sequencer: directed scenarios plus randomized pll_locked traffic,
// all compared every cycle against a phase/timestamp model of the sequencing rules.
module tb_pll_lock_sequencer;
    localparam int RST_C  = 4;
    localparam int TO_C   = 32;
    localparam int STB_C  = 8;
    localparam int SYNC_C = 2;
    localparam int MAXR_C = 4;

    logic       clk        = 1'b0;
    logic       rst        = 1'b1;
    logic       pll_locked = 1'b0;
    logic       pll_rst, sys_reset, ready, fail;
    logic [7:0] loss_cnt;

    int n_tests = 0;
    int n_fail  = 0;
    int tb_cyc  = 0;

    pll_lock_sequencer #(
        .RST_CYCLES   (RST_C),
        .LOCK_TIMEOUT (TO_C),
        .STABLE_CYCLES(STB_C),
        .SYNC_STAGES  (SYNC_C),
        .MAX_RETRIES  (MAXR_C)
    ) dut (
        .refclk_i       (clk),
        .rst_i          (rst),
        .pll_locked_i   (pll_locked),
        .pll_rst_o      (pll_rst),
        .sys_reset_o    (sys_reset),
        .ready_o        (ready),
        .fail_o         (fail),
        .lock_loss_cnt_o(loss_cnt)
    );

    always #5 clk = ~clk;

    // Edges since reset release; "cycle k" is the interval following edge k.
    always @(posedge clk or posedge rst) begin
        if (rst) tb_cyc <= 0;
        else     tb_cyc <= tb_cyc + 1;
    end

    task automatic chk(input string name, input int act, input int exp);
        n_tests++;
        if (act != exp) begin
            n_fail++;
            $display("[TB] FAIL %s at cycle %0d: got %0d, expected %0d", name, tb_cyc, act, exp);
        end
    endtask

    // Reference model: phase + entry timestamp + run length of locked samples.
    localparam int P_RST = 0, P_LOCK = 1, P_RUN = 2, P_FAIL = 3;
    int m_phase, m_start, m_cyc, m_streak, m_loss;
`ifdef PLL_RETRY_LIMIT_EN
    int m_retry;
`endif
    bit ls_q[$];

    task automatic m_enter(input int p);
        m_phase  = p;
        m_start  = m_cyc;
        m_streak = 0;
    endtask

    task automatic m_reset();
        m_phase = P_RST; m_start = 0; m_cyc = 0; m_streak = 0; m_loss = 0;
`ifdef PLL_RETRY_LIMIT_EN
        m_retry = 0;
`endif
        ls_q.delete();
        for (int i = 0; i < SYNC_C; i++) ls_q.push_back(1'b0);
    endtask

    task automatic m_step(input bit din);
        bit ls;
        m_cyc++;
        ls = ls_q.pop_front();
        ls_q.push_back(din);
        case (m_phase)
            P_RST:  if (m_cyc - m_start == RST_C) m_enter(P_LOCK);
            P_LOCK: begin
                if (ls) begin
                    m_streak++;
                    if (m_streak == STB_C) begin
`ifdef PLL_RETRY_LIMIT_EN
                        m_retry = 0;
`endif
                        m_enter(P_RUN);
                    end
                end else if (m_streak > 0) begin
                    m_enter(P_RST);
                end else if (m_cyc - m_start == TO_C) begin
`ifdef PLL_RETRY_LIMIT_EN
                    if (m_retry == MAXR_C - 1) m_enter(P_FAIL);
                    else begin m_retry++; m_enter(P_RST); end
`else
                    m_enter(P_RST);
`endif
                end
            end
            P_RUN: if (!ls) begin
                if (m_loss < 255) m_loss++;
                m_enter(P_RST);
            end
            default: ;
        endcase
    endtask

    initial begin
        m_reset();
        forever begin
            @(posedge clk or posedge rst);
            if (rst) m_reset();
            else     m_step(pll_locked);
        end
    end

    initial begin
        forever begin
            @(negedge clk);
            chk("m_pll_rst",   pll_rst,   (m_phase == P_RST) || (m_phase == P_FAIL));
            chk("m_sys_reset", sys_reset, m_phase != P_RUN);
            chk("m_ready",     ready,     m_phase == P_RUN);
            chk("m_fail",      fail,      m_phase == P_FAIL);
            chk("m_loss_cnt",  loss_cnt,  m_loss);
        end
    end

    task automatic wait_neg(input int k);
        do @(negedge clk); while (tb_cyc < k);
    endtask

    task automatic do_reset();
        @(negedge clk); #1;
        rst = 1'b1; pll_locked = 1'b0;
        repeat (2) @(negedge clk);
        #1 rst = 1'b0;
    endtask

    // Bounded wait on ready (sel=1) or pll_rst (sel=0); the final compare flags an expired bound.
    task automatic wait_sig(input string name, input bit sel, input bit val, input int bound);
        int n = 0;
        while (((sel ? ready : pll_rst) !== val) && n < bound) begin
            @(negedge clk);
            n++;
        end
        chk(name, sel ? ready : pll_rst, val);
    endtask

    initial begin
        // 1: first lock after reset
        do_reset();
        chk("s1_reset_pll_rst", pll_rst, 1);
        chk("s1_reset_sys_reset", sys_reset, 1);
        chk("s1_reset_ready", ready, 0);
        chk("s1_reset_cnt", loss_cnt, 0);
        wait_neg(3);  chk("s1_pll_rst_c3", pll_rst, 1);
        wait_neg(4);  chk("s1_pll_rst_c4", pll_rst, 0);
        wait_neg(5);  #1 pll_locked = 1'b1;
        wait_neg(14); chk("s1_sys_reset_c14", sys_reset, 1);
        wait_neg(15); chk("s1_sys_reset_c15", sys_reset, 0);
        chk("s1_ready", ready, 1);
        chk("s1_cnt", loss_cnt, 0);
        $display("[TB] scenario 1 first lock, cycle %0d", tb_cyc);

        // 3: one-cycle drop in RUN
        wait_neg(20); #1 pll_locked = 1'b0;
        wait_neg(21); #1 pll_locked = 1'b1;
        wait_neg(22); chk("s3_sys_reset_c22", sys_reset, 0);
        wait_neg(23); chk("s3_sys_reset_c23", sys_reset, 1);
        chk("s3_cnt", loss_cnt, 1);
        wait_neg(34); chk("s3_ready_c34", ready, 0);
        wait_neg(35); chk("s3_ready_c35", ready, 1);
        $display("[TB] scenario 3 run lock loss, cycle %0d", tb_cyc);

        // 4: drop during the stable window
        do_reset();
        wait_neg(5);  #1 pll_locked = 1'b1;
        wait_neg(11); #1 pll_locked = 1'b0;
        wait_neg(12); #1 pll_locked = 1'b1;
        wait_neg(13); chk("s4_pll_rst_c13", pll_rst, 0);
        wait_neg(14); chk("s4_pll_rst_c14", pll_rst, 1);
        chk("s4_sys_reset", sys_reset, 1);
        chk("s4_cnt", loss_cnt, 0);
        wait_neg(26); chk("s4_ready_c26", ready, 1);
        $display("[TB] scenario 4 stable drop, cycle %0d", tb_cyc);

        // 5: lock-loss counter saturation, then reset during WAIT_LOCK
        for (int i = 0; i < 300; i++) begin
            wait_sig("s5_ready_up", 1'b1, 1'b1, 60);
            @(negedge clk); #1 pll_locked = 1'b0;
            @(negedge clk); #1 pll_locked = 1'b1;
            wait_sig("s5_ready_down", 1'b1, 1'b0, 10);
        end
        wait_sig("s5_ready_final", 1'b1, 1'b1, 60);
        chk("s5_cnt_sat", loss_cnt, 255);
        @(negedge clk); #1 pll_locked = 1'b0;
        wait_sig("s5_pll_rst_up", 1'b0, 1'b1, 10);
        wait_sig("s5_pll_rst_down", 1'b0, 1'b0, 10);
        chk("s5_cnt_held", loss_cnt, 255);
        #1 rst = 1'b1;
        #1;
        chk("s5_async_pll_rst", pll_rst, 1);
        chk("s5_async_sys_reset", sys_reset, 1);
        chk("s5_async_ready", ready, 0);
        chk("s5_async_fail", fail, 0);
        chk("s5_async_cnt", loss_cnt, 0);
        @(negedge clk); #1 rst = 1'b0;
        $display("[TB] scenario 5 saturation and async reset, cycle %0d", tb_cyc);

        // 2: no lock at all
        do_reset();
        wait_neg(36);  chk("s2_pll_rst_c36", pll_rst, 1);
        wait_neg(39);  chk("s2_pll_rst_c39", pll_rst, 1);
        wait_neg(40);  chk("s2_pll_rst_c40", pll_rst, 0);
        wait_neg(72);  chk("s2_pll_rst_c72", pll_rst, 1);
        wait_neg(144); chk("s2_pll_rst_c144", pll_rst, 1);
`ifdef PLL_RETRY_LIMIT_EN
        chk("s2_fail_c144", fail, 1);
        wait_neg(148); chk("s2_pll_rst_c148", pll_rst, 1);
        wait_neg(200); chk("s2_fail_c200", fail, 1);
`else
        chk("s2_fail_c144", fail, 0);
        wait_neg(148); chk("s2_pll_rst_c148", pll_rst, 0);
        wait_neg(180); chk("s2_pll_rst_c180", pll_rst, 1);
`endif
        $display("[TB] scenario 2 timeout retries, cycle %0d", tb_cyc);

        // 6: lock arrives on the timeout cycle
        do_reset();
        wait_neg(33); #1 pll_locked = 1'b1;
        wait_neg(36); chk("s6_pll_rst_c36", pll_rst, 0);
        chk("s6_sys_reset_c36", sys_reset, 1);
        wait_neg(42); chk("s6_sys_reset_c42", sys_reset, 1);
        wait_neg(43); chk("s6_sys_reset_c43", sys_reset, 0);
        chk("s6_ready_c43", ready, 1);
        $display("[TB] scenario 6 lock on timeout cycle, cycle %0d", tb_cyc);

        // Randomized pll_locked segments with occasional glitches and resets
        do_reset();
        for (int s = 0; s < 200; s++) begin
            bit v;
            int len;
            v = ($urandom_range(0, 3) != 0);
            if ($urandom_range(0, 3) == 0) len = $urandom_range(1, 3);
            else                           len = v ? $urandom_range(5, 60) : $urandom_range(5, 90);
            pll_locked = v;
            repeat (len) @(negedge clk);
            #1;
            if ($urandom_range(0, 39) == 0) begin
                rst = 1'b1;
                @(negedge clk);
                #1 rst = 1'b0;
            end
        end
        $display("[TB] random phase done, model lock losses %0d", m_loss);

        repeat (4) @(negedge clk);
        #1;
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
